axi_multi_port_bridge: RTL and testbench

Parametrised successor to the two-port (inst/data) SRAM-to-AXI4 bridge. Arbitrates NUM_PORTS cache-side request ports onto one AXI4 full master interface, with INCR bursts for line fills and write-backs. Sits between the ICache/DCache (plus future MMU/DMA ports) and the AXI memory. One transaction is outstanding at a time.

---
 rtl/axi_multi_port_bridge.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_axi_multi_port_bridge.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_multi_port_bridge.sv
// axi_multi_port_bridge: arbitrates N cache request ports onto one AXI4 master.
// Macro BRIDGE_FIXED_PRIO_EN selects fixed lowest-index priority over round-robin.
module axi_multi_port_bridge #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                              aclk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              port_ce,
  input  logic [NUM_PORTS-1:0]              port_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   port_addr,
  input  logic [NUM_PORTS*8-1:0]            port_len,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   port_wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] port_wmask,
  output logic [NUM_PORTS-1:0]              port_wdata_ready,
  output logic [DATA_WIDTH-1:0]             port_rdata,
  output logic [NUM_PORTS-1:0]              port_rdata_valid,
  output logic [NUM_PORTS-1:0]              port_rdata_last,
  output logic [NUM_PORTS-1:0]              port_write_finish,
  output logic                              ar_valid,
  input  logic                              ar_ready,
  output logic [ADDR_WIDTH-1:0]             ar_addr,
  output logic [ID_WIDTH-1:0]               ar_id,
  output logic [7:0]                        ar_len,
  output logic [2:0]                        ar_size,
  output logic [1:0]                        ar_burst,
  output logic                              ar_lock,
  output logic [3:0]                        ar_cache,
  output logic [2:0]                        ar_prot,
  output logic                              aw_valid,
  input  logic                              aw_ready,
  output logic [ADDR_WIDTH-1:0]             aw_addr,
  output logic [ID_WIDTH-1:0]               aw_id,
  output logic [7:0]                        aw_len,
  output logic [2:0]                        aw_size,
  output logic [1:0]                        aw_burst,
  output logic                              aw_lock,
  output logic [3:0]                        aw_cache,
  output logic [2:0]                        aw_prot,
  input  logic                              rd_valid,
  output logic                              rd_ready,
  input  logic [DATA_WIDTH-1:0]             rd_data,
  input  logic [ID_WIDTH-1:0]               rd_id,
  input  logic [1:0]                        rd_resp,
  input  logic                              rd_last,
  output logic                              wd_valid,
  input  logic                              wd_ready,
  output logic [DATA_WIDTH-1:0]             wd_data,
  output logic [DATA_WIDTH/8-1:0]           wstrb,
  output logic [ID_WIDTH-1:0]               wd_id,
  output logic                              wd_last,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [1:0]                        wr_breap,
  input  logic [ID_WIDTH-1:0]               wr_id
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [2:0] AX_SIZE = 3'($clog2(STRB_W));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_hit;
  logic [IDX_W-1:0]      gnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]            sel_len;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] gnt_wdata;
  logic [STRB_W-1:0]     gnt_wmask;
  logic [NUM_PORTS-1:0]  gnt_oh;
  logic                  resp_unused;

  // Error responses and IDs are not checked; the beat is taken regardless.
  assign resp_unused = ^{rd_resp, rd_id, wr_breap, wr_id};

`ifdef BRIDGE_FIXED_PRIO_EN
  // Lowest-index requester wins.
  always_comb begin
    arb_idx = '0;
    arb_hit = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (port_ce[i]) begin
        arb_idx = IDX_W'(i);
        arb_hit = 1'b1;
      end
    end
  end
`else
  localparam logic [IDX_W:0] NP_W = (IDX_W + 1)'(NUM_PORTS);

  logic [IDX_W-1:0]     ptr_q;
  logic [NUM_PORTS-1:0] ce_rot;
  logic [IDX_W-1:0]     rr_off;
  logic [IDX_W:0]       rr_sum;

  assign ce_rot = NUM_PORTS'({port_ce, port_ce} >> ptr_q);

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    rr_off  = '0;
    arb_hit = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (ce_rot[i]) begin
        rr_off  = IDX_W'(i);
        arb_hit = 1'b1;
      end
    end
    rr_sum = {1'b0, ptr_q} + {1'b0, rr_off};
    if (rr_sum >= NP_W) begin
      rr_sum = rr_sum - NP_W;
    end
    arb_idx = rr_sum[IDX_W-1:0];
  end

  // Pointer moves past the port just served.
  always_ff @(posedge aclk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (state_q == S_DONE) begin
      ptr_q <= (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
    end
  end
`endif

  // Request fields of the port being granted.
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_we   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_addr = port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = port_len[i*8 +: 8];
        sel_we   = port_we[i];
      end
    end
  end

  // Current write beat of the port holding the grant.
  always_comb begin
    gnt_wdata = '0;
    gnt_wmask = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_q == IDX_W'(i)) begin
        gnt_wdata = port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_wmask = port_wmask[i*STRB_W +: STRB_W];
      end
    end
  end

  // State register.
  always_ff @(posedge aclk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (arb_hit) begin
          state_d = sel_we ? S_AW : S_AR;
        end
      end
      S_AR: begin
        if (ar_ready) begin
          state_d = S_R;
        end
      end
      S_R: begin
        if (rd_valid && rd_last) begin
          state_d = S_DONE;
        end
      end
      S_AW: begin
        if (aw_ready) begin
          state_d = S_W;
        end
      end
      S_W: begin
        if (wd_ready && cnt_q == 8'd0) begin
          state_d = S_B;
        end
      end
      S_B: begin
        if (wr_valid) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant latch and write beat counter.
  always_ff @(posedge aclk or negedge reset) begin
    if (!reset) begin
      gnt_q  <= '0;
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (state_q == S_IDLE && arb_hit) begin
        gnt_q  <= arb_idx;
        addr_q <= sel_addr;
        len_q  <= sel_len;
      end
      if (state_q == S_AW && aw_ready) begin
        cnt_q <= len_q;
      end else if (state_q == S_W && wd_ready) begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  assign gnt_oh = NUM_PORTS'(1) << gnt_q;

  assign ar_valid = (state_q == S_AR);
  assign ar_addr  = addr_q;
  assign ar_id    = ID_WIDTH'(gnt_q);
  assign ar_len   = len_q;
  assign ar_size  = AX_SIZE;
  assign ar_burst = 2'b01;
  assign ar_lock  = 1'b0;
  assign ar_cache = 4'd0;
  assign ar_prot  = 3'd0;

  assign aw_valid = (state_q == S_AW);
  assign aw_addr  = addr_q;
  assign aw_id    = ID_WIDTH'(gnt_q);
  assign aw_len   = len_q;
  assign aw_size  = AX_SIZE;
  assign aw_burst = 2'b01;
  assign aw_lock  = 1'b0;
  assign aw_cache = 4'd0;
  assign aw_prot  = 3'd0;

  assign rd_ready = (state_q == S_R);
  assign wr_ready = (state_q == S_B);

  assign wd_valid = (state_q == S_W);
  assign wd_data  = wd_valid ? gnt_wdata : '0;
  assign wstrb    = wd_valid ? gnt_wmask : '0;
  assign wd_id    = ID_WIDTH'(gnt_q);
  assign wd_last  = wd_valid && (cnt_q == 8'd0);

  assign port_rdata = rd_ready ? rd_data : '0;

  assign port_rdata_valid =
    (rd_ready && rd_valid) ? gnt_oh : '0;
  assign port_rdata_last =
    (rd_ready && rd_valid && rd_last) ? gnt_oh : '0;
  assign port_wdata_ready =
    (wd_valid && wd_ready) ? gnt_oh : '0;
  assign port_write_finish =
    (wr_ready && wr_valid) ? gnt_oh : '0;

endmodule

// File: tb/tb_axi_multi_port_bridge.sv
// tb_axi_multi_port_bridge: directed + randomized bench with a memory slave
// model and a round-robin grant model; also covers a 4-port 64-bit build.
module tb_axi_multi_port_bridge;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int SB = DW / 8;

  logic aclk = 1'b0;
  logic reset;

  logic [NP-1:0]    port_ce;
  logic [NP-1:0]    port_we;
  logic [NP*AW-1:0] port_addr;
  logic [NP*8-1:0]  port_len;
  logic [NP*DW-1:0] port_wdata;
  logic [NP*SB-1:0] port_wmask;
  logic [NP-1:0]    port_wdata_ready;
  logic [DW-1:0]    port_rdata;
  logic [NP-1:0]    port_rdata_valid;
  logic [NP-1:0]    port_rdata_last;
  logic [NP-1:0]    port_write_finish;
  logic ar_valid, ar_ready, ar_lock;
  logic [AW-1:0] ar_addr;
  logic [IW-1:0] ar_id;
  logic [7:0] ar_len;
  logic [2:0] ar_size, ar_prot;
  logic [1:0] ar_burst;
  logic [3:0] ar_cache;
  logic aw_valid, aw_ready, aw_lock;
  logic [AW-1:0] aw_addr;
  logic [IW-1:0] aw_id;
  logic [7:0] aw_len;
  logic [2:0] aw_size, aw_prot;
  logic [1:0] aw_burst;
  logic [3:0] aw_cache;
  logic rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic [IW-1:0] rd_id;
  logic [1:0] rd_resp;
  logic wd_valid, wd_ready, wd_last;
  logic [DW-1:0] wd_data;
  logic [SB-1:0] wstrb;
  logic [IW-1:0] wd_id;
  logic wr_valid, wr_ready;
  logic [1:0] wr_breap;
  logic [IW-1:0] wr_id;

  // 4-port, 64-bit build
  logic [3:0]   c4_ce, c4_we, c4_wdata_ready;
  logic [127:0] c4_addr;
  logic [31:0]  c4_len, c4_wmask;
  logic [255:0] c4_wdata;
  logic [63:0]  c4_rdata;
  logic [3:0]   c4_rdata_valid, c4_rdata_last, c4_write_finish;
  logic c4_ar_valid, c4_ar_ready, c4_ar_lock;
  logic [31:0] c4_ar_addr;
  logic [3:0] c4_ar_id, c4_ar_cache;
  logic [7:0] c4_ar_len;
  logic [2:0] c4_ar_size, c4_ar_prot;
  logic [1:0] c4_ar_burst;
  logic c4_aw_valid, c4_aw_ready, c4_aw_lock;
  logic [31:0] c4_aw_addr;
  logic [3:0] c4_aw_id, c4_aw_cache;
  logic [7:0] c4_aw_len;
  logic [2:0] c4_aw_size, c4_aw_prot;
  logic [1:0] c4_aw_burst;
  logic c4_rd_valid, c4_rd_ready, c4_rd_last;
  logic [63:0] c4_rd_data;
  logic [3:0] c4_rd_id;
  logic [1:0] c4_rd_resp;
  logic c4_wd_valid, c4_wd_ready, c4_wd_last;
  logic [63:0] c4_wd_data;
  logic [7:0] c4_wstrb;
  logic [3:0] c4_wd_id;
  logic c4_wr_valid, c4_wr_ready;
  logic [1:0] c4_wr_breap;
  logic [3:0] c4_wr_id;
  logic c4_unused;

  assign c4_unused = ^{c4_wdata_ready, c4_write_finish, c4_ar_addr,
                       c4_ar_lock, c4_ar_cache, c4_ar_prot, c4_ar_burst,
                       c4_aw_addr, c4_aw_id, c4_aw_cache, c4_aw_len,
                       c4_aw_size, c4_aw_prot, c4_aw_burst, c4_aw_lock,
                       c4_wd_data, c4_wstrb, c4_wd_id, c4_wd_last};

  int tests = 0;
  int fails = 0;
  int ptr_m = 0;

  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] wbeat [NP][256];
  logic [SB-1:0] wmask_m [NP];
  logic [7:0]    len_m [NP];
  logic [AW-1:0] addr_m [NP];
  logic          we_m [NP];

  always #5 aclk = ~aclk;

  axi_multi_port_bridge #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)
  ) dut (
    .aclk(aclk), .reset(reset),
    .port_ce(port_ce), .port_we(port_we),
    .port_addr(port_addr), .port_len(port_len),
    .port_wdata(port_wdata), .port_wmask(port_wmask),
    .port_wdata_ready(port_wdata_ready), .port_rdata(port_rdata),
    .port_rdata_valid(port_rdata_valid),
    .port_rdata_last(port_rdata_last),
    .port_write_finish(port_write_finish),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .ar_id(ar_id), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_lock(ar_lock), .ar_cache(ar_cache),
    .ar_prot(ar_prot),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .aw_id(aw_id), .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst), .aw_lock(aw_lock), .aw_cache(aw_cache),
    .aw_prot(aw_prot),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_id(rd_id), .rd_resp(rd_resp), .rd_last(rd_last),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .wstrb(wstrb), .wd_id(wd_id), .wd_last(wd_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_breap(wr_breap),
    .wr_id(wr_id)
  );

  axi_multi_port_bridge #(
    .NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)
  ) dut4 (
    .aclk(aclk), .reset(reset),
    .port_ce(c4_ce), .port_we(c4_we),
    .port_addr(c4_addr), .port_len(c4_len),
    .port_wdata(c4_wdata), .port_wmask(c4_wmask),
    .port_wdata_ready(c4_wdata_ready), .port_rdata(c4_rdata),
    .port_rdata_valid(c4_rdata_valid),
    .port_rdata_last(c4_rdata_last),
    .port_write_finish(c4_write_finish),
    .ar_valid(c4_ar_valid), .ar_ready(c4_ar_ready),
    .ar_addr(c4_ar_addr), .ar_id(c4_ar_id), .ar_len(c4_ar_len),
    .ar_size(c4_ar_size), .ar_burst(c4_ar_burst),
    .ar_lock(c4_ar_lock), .ar_cache(c4_ar_cache),
    .ar_prot(c4_ar_prot),
    .aw_valid(c4_aw_valid), .aw_ready(c4_aw_ready),
    .aw_addr(c4_aw_addr), .aw_id(c4_aw_id), .aw_len(c4_aw_len),
    .aw_size(c4_aw_size), .aw_burst(c4_aw_burst),
    .aw_lock(c4_aw_lock), .aw_cache(c4_aw_cache),
    .aw_prot(c4_aw_prot),
    .rd_valid(c4_rd_valid), .rd_ready(c4_rd_ready),
    .rd_data(c4_rd_data), .rd_id(c4_rd_id), .rd_resp(c4_rd_resp),
    .rd_last(c4_rd_last),
    .wd_valid(c4_wd_valid), .wd_ready(c4_wd_ready),
    .wd_data(c4_wd_data), .wstrb(c4_wstrb), .wd_id(c4_wd_id),
    .wd_last(c4_wd_last),
    .wr_valid(c4_wr_valid), .wr_ready(c4_wr_ready),
    .wr_breap(c4_wr_breap), .wr_id(c4_wr_id)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_0F0F;
  endfunction

  // Grant choice from the arbitration rule alone.
  function automatic int model_grant(input logic [NP-1:0] ce);
`ifdef BRIDGE_FIXED_PRIO_EN
    for (int i = 0; i < NP; i++) if (ce[i]) return i;
`else
    for (int i = 0; i < NP; i++) begin
      if (ce[(ptr_m + i) % NP]) return (ptr_m + i) % NP;
    end
`endif
    return -1;
  endfunction

  task automatic req(input int p, input logic we, input logic [AW-1:0] a,
                     input logic [7:0] l, input logic [SB-1:0] m);
    we_m[p] = we;
    addr_m[p] = a;
    len_m[p] = l;
    wmask_m[p] = m;
    for (int k = 0; k <= int'(l); k++) wbeat[p][k] = $urandom;
    port_we[p] = we;
    port_addr[p*AW +: AW] = a;
    port_len[p*8 +: 8] = l;
    port_wdata[p*DW +: DW] = wbeat[p][0];
    port_wmask[p*SB +: SB] = m;
    port_ce[p] = 1'b1;
  endtask

  // Acts as the AXI slave for one transaction; called at a negedge.
  task automatic serve(input int dly, input bit bp, input int abort_at);
    int g, n, i, pulses, bw, len;
    logic is_wr, hs;
    logic [AW-1:0] a0, wa;
    logic [DW-1:0] w;
    logic [NP-1:0] oh;
    check("req_pending", {63'd0, |port_ce}, 64'd1);
    g = model_grant(port_ce);
    if (g < 0) return;
    oh = NP'(1) << g;
    len = int'(len_m[g]);
    n = 0;
    do begin
      @(negedge aclk);
      #1;
      n++;
    end while (!(ar_valid || aw_valid) && n < 20);
    check("ax_valid_seen", {63'd0, ar_valid | aw_valid}, 64'd1);
    if (!(ar_valid || aw_valid)) return;
    is_wr = aw_valid;
    check("ax_dir", {63'd0, is_wr}, {63'd0, we_m[g]});
    check("grant_id", is_wr ? aw_id : ar_id, g);
    a0 = is_wr ? aw_addr : ar_addr;
    check("ax_addr", a0, addr_m[g]);
    check("ax_len", is_wr ? aw_len : ar_len, len);
    check("ax_size", is_wr ? aw_size : ar_size, $clog2(SB));
    check("ax_burst", is_wr ? aw_burst : ar_burst, 2'b01);
    check("ax_attr", is_wr ? {aw_lock, aw_cache, aw_prot}
                           : {ar_lock, ar_cache, ar_prot}, 0);
    for (int k = 0; k < dly; k++) begin
      @(negedge aclk);
      #1;
      check("ax_valid_hold", is_wr ? aw_valid : ar_valid, 1);
      check("ax_addr_hold", is_wr ? aw_addr : ar_addr, a0);
    end
    if (is_wr) aw_ready = 1'b1;
    else ar_ready = 1'b1;
    @(negedge aclk);
    aw_ready = 1'b0;
    ar_ready = 1'b0;
    #1;
    check("ax_valid_drop", {63'd0, ar_valid | aw_valid}, 64'd0);
    i = 0;
    n = 0;
    if (!is_wr) begin
      pulses = 0;
      while (i <= len && n < 400) begin
        rd_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        rd_data = mem_rd(addr_m[g] + AW'(i * SB));
        rd_last = (i == len);
        rd_id = IW'(g);
        #1;
        check("rd_ready", rd_ready, 1);
        check("rdata_valid", port_rdata_valid, rd_valid ? oh : '0);
        if (rd_valid) begin
          pulses++;
          check("rdata", port_rdata, rd_data);
          check("rdata_last", port_rdata_last, rd_last ? oh : '0);
          i++;
        end
        n++;
        @(negedge aclk);
      end
      rd_valid = 1'b0;
      rd_last = 1'b0;
      port_ce[g] = 1'b0;
      #1;
      check("read_beats", pulses, len + 1);
      check("read_done_quiet", {rd_ready, port_rdata_valid}, 0);
    end else begin
      while (i <= len && n < 400) begin
        wd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        check("wd_valid", wd_valid, 1);
        check("wd_data", wd_data, wbeat[g][i]);
        check("wstrb", wstrb, wmask_m[g]);
        check("wd_last", wd_last, i == len);
        check("wd_id", wd_id, g);
        check("wdata_ready", port_wdata_ready, wd_ready ? oh : '0);
        hs = wd_ready;
        n++;
        @(negedge aclk);
        if (hs) begin
          wa = addr_m[g] + AW'(i * SB);
          w = mem_rd(wa);
          for (int b = 0; b < SB; b++) begin
            if (wmask_m[g][b]) w[b*8 +: 8] = wbeat[g][i][b*8 +: 8];
          end
          mem[wa] = w;
          i++;
          if (i <= len) port_wdata[g*DW +: DW] = wbeat[g][i];
          if (i == abort_at) begin
            wd_ready = 1'b0;
            return;
          end
        end
      end
      wd_ready = 1'b0;
      check("write_beats", i, len + 1);
      bw = $urandom_range(0, 3);
      for (int k = 0; k < bw; k++) begin
        #1;
        check("wr_ready", wr_ready, 1);
        check("finish_early", port_write_finish, 0);
        @(negedge aclk);
      end
      wr_valid = 1'b1;
      wr_id = IW'(g);
      #1;
      check("write_finish", port_write_finish, oh);
      @(negedge aclk);
      wr_valid = 1'b0;
      port_ce[g] = 1'b0;
      #1;
      check("write_done_quiet", {wr_ready, port_write_finish}, 0);
    end
    ptr_m = (g + 1) % NP;
  endtask

  initial begin
    int n;
    reset = 1'b0;
    port_ce = '0; port_we = '0; port_addr = '0; port_len = '0;
    port_wdata = '0; port_wmask = '0;
    ar_ready = 0; aw_ready = 0; rd_valid = 0; rd_data = '0;
    rd_id = '0; rd_resp = '0; rd_last = 0; wd_ready = 0;
    wr_valid = 0; wr_breap = '0; wr_id = '0;
    c4_ce = '0; c4_we = '0; c4_addr = '0; c4_len = '0;
    c4_wdata = '0; c4_wmask = '0; c4_ar_ready = 0; c4_aw_ready = 0;
    c4_rd_valid = 0; c4_rd_data = '0; c4_rd_id = '0; c4_rd_resp = '0;
    c4_rd_last = 0; c4_wd_ready = 0; c4_wr_valid = 0;
    c4_wr_breap = '0; c4_wr_id = '0;

    repeat (3) @(negedge aclk);
    #1;
    check("rst_valids", {ar_valid, aw_valid, wd_valid, rd_ready, wr_ready}, 0);
    check("rst_pulses", {port_wdata_ready, port_rdata_valid,
                         port_rdata_last, port_write_finish}, 0);
    check("rst_addr", {ar_addr, aw_addr}, 0);
    check("rst_data", {wd_data, port_rdata}, 0);
    check("rst4_valids", {c4_ar_valid, c4_aw_valid, c4_wd_valid,
                          c4_rd_ready, c4_wr_ready}, 0);
    @(negedge aclk);
    reset = 1'b1;

    // single read, port 0
    mem[32'h1C00_0000] = 32'h11;
    mem[32'h1C00_0004] = 32'h22;
    mem[32'h1C00_0008] = 32'h33;
    mem[32'h1C00_000C] = 32'h44;
    req(0, 1'b0, 32'h1C00_0000, 8'd3, '1);
    serve(0, 0, -1);

    // burst write, port 1, AW accepted late
    @(negedge aclk);
    req(1, 1'b1, 32'h100, 8'd1, 4'hF);
    wbeat[1][0] = 32'hAABB_CCDD;
    wbeat[1][1] = 32'h0102_0304;
    port_wdata[DW +: DW] = wbeat[1][0];
    serve(3, 0, -1);
    check("mem_wr0", mem_rd(32'h100), 32'hAABB_CCDD);

    // both ports keep requesting
    @(negedge aclk);
    for (int p = 0; p < NP; p++) begin
      req(p, 1'($urandom_range(0, 1)), {$urandom_range(0, 255), 2'b00},
          8'($urandom_range(0, 3)), SB'($urandom));
    end
    for (int t = 0; t < 4; t++) begin
      serve($urandom_range(0, 2), 1, -1);
      if (t < 3) begin
        for (int p = 0; p < NP; p++) begin
          if (!port_ce[p]) begin
            req(p, 1'($urandom_range(0, 1)),
                {$urandom_range(0, 255), 2'b00},
                8'($urandom_range(0, 3)), SB'($urandom));
          end
        end
      end
    end
    port_ce = '0;

    // 8-beat read under random rd_valid
    @(negedge aclk);
    req(1, 1'b0, {$urandom_range(256, 511), 2'b00}, 8'd7, '1);
    serve(1, 1, -1);

    // masked random write then read back on the other port
    @(negedge aclk);
    req(0, 1'b1, 32'h0000_8000, 8'd3, SB'($urandom));
    serve(0, 1, -1);
    @(negedge aclk);
    req(1, 1'b0, 32'h0000_8000, 8'd3, '1);
    serve(2, 1, -1);

    // reset in the middle of a write burst
    @(negedge aclk);
    req(0, 1'b1, 32'h200, 8'd3, '1);
    serve(0, 0, 1);
    wd_ready = 1'b1;
    reset = 1'b0;
    #1;
    check("rstw_valids", {ar_valid, aw_valid, wd_valid, rd_ready, wr_ready}, 0);
    check("rstw_pulses", {port_wdata_ready, port_rdata_valid,
                          port_write_finish}, 0);
    check("rstw_data", wd_data, 0);
    port_ce = '0;
    wd_ready = 1'b0;
    @(negedge aclk);
    reset = 1'b1;
    ptr_m = 0;
    repeat (2) begin
      @(negedge aclk);
      #1;
      check("idle_after_rst", {ar_valid, aw_valid, wd_valid}, 0);
    end
    req(1, 1'b0, 32'h200, 8'd1, '1);
    serve(0, 0, -1);

    // 4-port 64-bit build: port 3, single beat
    @(negedge aclk);
    c4_ce = 4'b1000;
    c4_addr[96 +: 32] = 32'h0000_4000;
    c4_len[24 +: 8] = 8'd0;
    n = 0;
    do begin
      @(negedge aclk);
      #1;
      n++;
    end while (!c4_ar_valid && n < 20);
    check("p4_ar_valid", c4_ar_valid, 1);
    check("p4_ar_id", c4_ar_id, 3);
    check("p4_ar_size", c4_ar_size, 3);
    check("p4_ar_len", c4_ar_len, 0);
    c4_ar_ready = 1'b1;
    @(negedge aclk);
    c4_ar_ready = 1'b0;
    c4_rd_valid = 1'b1;
    c4_rd_last = 1'b1;
    c4_rd_data = {$urandom, $urandom};
    c4_rd_id = 4'd3;
    #1;
    check("p4_rvalid", c4_rdata_valid, 4'b1000);
    check("p4_rlast", c4_rdata_last, 4'b1000);
    check("p4_rdata", c4_rdata, c4_rd_data);
    @(negedge aclk);
    c4_rd_valid = 1'b0;
    c4_rd_last = 1'b0;
    c4_ce = '0;
    #1;
    check("p4_done", {c4_rd_ready, c4_rdata_valid}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
